spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
// - SPI slave endpoint downstream of the SPI master; decodes command byte + burst data from SCLK/MOSI/SS, serves reads on MISO.
// - Holds NUM_REGS x 8-bit register bank, mirrored to fabric on reg_out; pulses strobes per committed byte.
// - All SPI inputs oversampled in clk domain; SCLK half-period must be >= 8 clk cycles.
// PARAMETERS
// - NUM_REGS  4  register count; power of two, 2..64
// - ADDR_W    2  log2(NUM_REGS); address = cmd[ADDR_W-1:0]
// PORTS
// - clk        in   1               system clock; one clock domain
// - reset      in   1               synchronous, active-high reset
// - cpol       in   1               SCLK idle level; static while SS low
// - cpha       in   1               0: sample leading edge; 1: sample trailing edge
// - SCLK       in   1               SPI clock from master (async to clk)
// - MOSI       in   1               SPI data in, MSB first
// - SS         in   1               slave select, active-low
// - MISO       out  1               SPI data out, MSB first
// - miso_oe    out  1               MISO drive enable (=1 only while selected)
// - wr_strobe  out  1               1-clk pulse: register written from SPI
// - rd_strobe  out  1               1-clk pulse: register byte fully shifted out
// - acc_addr   out  ADDR_W          address of the strobed access
// - acc_data   out  8               data of the strobed access
// - busy       out  1               1 while transaction active (SS low, synced)
// - reg_out    out  NUM_REGS*8      flat register bank, reg k at [8k+7:8k]
// BEHAVIOUR
// - Reset (sync, highest priority, valid mid-transaction): all regs 0, MISO 0, miso_oe 0, strobes 0, acc_* 0, busy 0, state IDLE, bit counter 0.
// - SCLK, MOSI, SS each pass 2-flop synchronizer; edges from 3rd flop of SCLK. nsclk = sclk_sync ^ cpol.
// - Leading edge = nsclk 0->1; trailing = 1->0. Sample edge = leading if cpha=0 else trailing; shift edge = the other.
// - Sample edge: rx_sr <= {rx_sr[6:0], MOSI_sync}; bit_cnt++ (3-bit, wraps 7->0 = byte complete).
// - FSM: IDLE -> CMD on SS_sync falling; CMD -> WDATA/RDATA on 8th sample; any state -> IDLE on SS_sync rising (abort).
// - CMD byte: cmd[7]=1 write, 0 read; addr_ptr <= cmd[ADDR_W-1:0]; cmd[6:ADDR_W] ignored. MISO=0 during CMD.
// - WDATA: each completed byte -> regs[addr_ptr] <= byte, wr_strobe=1, acc_addr=addr_ptr, acc_data=byte, same cycle; addr_ptr++.
// - RDATA: tx_sr loaded with regs[addr_ptr] at byte start; MISO = tx_sr[7]; shift edge shifts left (fill 0).
// - Byte start, cpha=0: tx_sr loaded at the shift (trailing) edge ending the previous byte instead of shifting.
// - Byte start, cpha=1: tx_sr loaded at the first leading edge of the byte instead of shifting.
// - RDATA completed byte: rd_strobe=1, acc_addr=addr_ptr, acc_data=sent byte; addr_ptr++. MOSI data ignored.
// - addr_ptr wraps modulo NUM_REGS (NUM_REGS-1 -> 0); bursts unbounded.
// - Write commit latency <= 4 clk after physical SCLK sample edge; strobes exactly 1 clk wide.
// - Abort: partial byte discarded (no write, no strobe); bit_cnt <= 0, tx_sr <= 0, MISO=0, miso_oe=0.
// - miso_oe = ~SS_sync while not IDLE; busy = (state != IDLE).
// - SCLK edges while SS_sync high ignored; SS fall and SCLK edge in same clk: SS handled first, edge counted in CMD.
// - reg_out is registered and updates the cycle after wr_strobe.
// TESTING
// - Reset: hold reset 3 clk mid-burst -> all outputs 0, reg_out=0, busy=0; next transaction decodes normally.
// - Mode 0 write burst: cmd 0x81, data 0xA5, 0x3C -> 2 wr_strobes (addr 1/0xA5, addr 2/0x3C); reg_out=0x003CA500.
// - Wrap: cmd 0x83, data 0x11, 0x22 -> regs[3]=0x11, regs[0]=0x22; acc_addr sequence 3,0.
// - Mode 0 read: regs={0x22,0xA5,0x3C,0x11} (addr 0..3), cmd 0x02, 3 bytes -> MISO 0x3C,0x11,0x22; rd_strobe x3.
// - Mode 3 (cpol=1,cpha=1): repeat write 0x80,0x5A then read 0x00 -> MISO 0x5A; SCLK idles high, no spurious edges.
// - Abort: cmd 0x81, 4 data bits, SS high -> no wr_strobe, regs[1] unchanged; next cmd 0x81,0x77 writes regs[1]=0x77.

Source files
------------

// File: rtl/spi_slave_regfile_if.sv
// Pin and fabric-side bundle for the SPI slave register file.
// wr_strobe/rd_strobe are single-cycle qualifiers: acc_addr/acc_data are meaningful only in that cycle (no back-pressure).
interface spi_slave_regfile_if #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
);
  logic                  cpol;
  logic                  cpha;
  logic                  SCLK;
  logic                  MOSI;
  logic                  SS;
  logic                  MISO;
  logic                  miso_oe;
  logic                  wr_strobe;
  logic                  rd_strobe;
  logic [ADDR_W-1:0]     acc_addr;
  logic [7:0]            acc_data;
  logic                  busy;
  logic [NUM_REGS*8-1:0] reg_out;
  logic [1:0]            dbg_state;

  modport slave (
    input  cpol, cpha, SCLK, MOSI, SS,
    output MISO, miso_oe, wr_strobe, rd_strobe, acc_addr, acc_data, busy, reg_out, dbg_state
  );

  modport master (
    output cpol, cpha, SCLK, MOSI, SS,
    input  MISO, miso_oe, wr_strobe, rd_strobe, acc_addr, acc_data, busy, reg_out, dbg_state
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI slave with an oversampled front end: command byte selects read/write and start
// address, then unbounded auto-incrementing byte bursts against an 8-bit register bank.
module spi_slave_regfile #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_slave_regfile_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WDATA = 2'd2, RDATA = 2'd3} state_e;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q, sclk_s1_d, sclk_s2_d, sclk_s3_d;
  logic mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;
  logic ss_s1_q, ss_s2_q, ss_s3_q, ss_s1_d, ss_s2_d, ss_s3_d;

  state_e                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            rx_sr_q, rx_sr_d;
  logic [7:0]            tx_sr_q, tx_sr_d;
  logic [ADDR_W-1:0]     addr_ptr_q, addr_ptr_d;
  logic [NUM_REGS*8-1:0] regs_q, regs_d;
  logic [NUM_REGS*8-1:0] reg_out_q, reg_out_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic                  busy_q, busy_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic                  rd_strobe_q, rd_strobe_d;
  logic [ADDR_W-1:0]     acc_addr_q, acc_addr_d;
  logic [7:0]            acc_data_q, acc_data_d;

  logic nsclk_now, nsclk_prev, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;
  logic [7:0] byte_in;
  logic [7:0] cur_reg;

  always_comb begin
    sclk_s1_d = bus.SCLK;
    sclk_s2_d = sclk_s1_q;
    sclk_s3_d = sclk_s2_q;
    mosi_s1_d = bus.MOSI;
    mosi_s2_d = mosi_s1_q;
    ss_s1_d   = bus.SS;
    ss_s2_d   = ss_s1_q;
    ss_s3_d   = ss_s2_q;

    // Normalising by cpol makes "leading" always a 0->1 transition.
    nsclk_now   = sclk_s2_q ^ bus.cpol;
    nsclk_prev  = sclk_s3_q ^ bus.cpol;
    lead_edge   = ~nsclk_prev & nsclk_now;
    trail_edge  = nsclk_prev & ~nsclk_now;
    sample_edge = bus.cpha ? trail_edge : lead_edge;
    shift_edge  = bus.cpha ? lead_edge : trail_edge;
    ss_fall     = ss_s3_q & ~ss_s2_q;
    ss_rise     = ~ss_s3_q & ss_s2_q;
    byte_in     = {rx_sr_q[6:0], mosi_s2_q};
    cur_reg     = regs_q[{addr_ptr_q, 3'b000} +: 8];

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    addr_ptr_d  = addr_ptr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    rd_strobe_d = 1'b0;
    acc_addr_d  = acc_addr_q;
    acc_data_d  = acc_data_q;

    if (ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      tx_sr_d   = 8'h00;
    end else begin
      // A select and an SCLK edge landing together: enter CMD, then count the edge.
      if (state_q == IDLE && ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        tx_sr_d   = 8'h00;
      end
      if (state_d != IDLE && !ss_s2_q) begin
        if (sample_edge) begin
          rx_sr_d = byte_in;
          if (bit_cnt_d == 3'd7) begin
            unique case (state_d)
              CMD: begin
                addr_ptr_d = byte_in[ADDR_W-1:0];
                state_d    = byte_in[7] ? WDATA : RDATA;
              end
              WDATA: begin
                regs_d[{addr_ptr_q, 3'b000} +: 8] = byte_in;
                wr_strobe_d = 1'b1;
                acc_addr_d  = addr_ptr_q;
                acc_data_d  = byte_in;
                addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
              end
              RDATA: begin
                rd_strobe_d = 1'b1;
                acc_addr_d  = addr_ptr_q;
                acc_data_d  = cur_reg;
                addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
              end
              default: ;
            endcase
          end
          bit_cnt_d = bit_cnt_d + 3'd1;
        end else if (shift_edge && state_d == RDATA) begin
          // The first shift edge of each read byte loads instead of shifting, for either cpha.
          tx_sr_d = (bit_cnt_d == 3'd0) ? cur_reg : {tx_sr_q[6:0], 1'b0};
        end
      end
    end

    miso_d    = (state_d == RDATA) ? tx_sr_d[7] : 1'b0;
    miso_oe_d = (state_d != IDLE) & ~ss_s2_q;
    busy_d    = (state_d != IDLE);
    reg_out_d = regs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_s3_q   <= 1'b0;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      ss_s1_q     <= 1'b1;
      ss_s2_q     <= 1'b1;
      ss_s3_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      addr_ptr_q  <= '0;
      regs_q      <= '0;
      reg_out_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      acc_addr_q  <= '0;
      acc_data_q  <= 8'h00;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_s3_q   <= sclk_s3_d;
      mosi_s1_q   <= mosi_s1_d;
      mosi_s2_q   <= mosi_s2_d;
      ss_s1_q     <= ss_s1_d;
      ss_s2_q     <= ss_s2_d;
      ss_s3_q     <= ss_s3_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      addr_ptr_q  <= addr_ptr_d;
      regs_q      <= regs_d;
      reg_out_q   <= reg_out_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      acc_addr_q  <= acc_addr_d;
      acc_data_q  <= acc_data_d;
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.miso_oe   = miso_oe_q;
  assign bus.busy      = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.rd_strobe = rd_strobe_q;
  assign bus.acc_addr  = acc_addr_q;
  assign bus.acc_data  = acc_data_q;
  assign bus.reg_out   = reg_out_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile: table of SPI transactions in all four modes,
// plus hand-written abort and mid-burst reset sequences.
module tb_spi_slave_regfile;

  localparam int H = 10;  // SCLK half-period in clk cycles

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_regfile_if #(.NUM_REGS(4), .ADDR_W(2)) bus ();
  spi_slave_regfile #(.NUM_REGS(4), .ADDR_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic        cpol;
    logic        cpha;
    logic [7:0]  cmd;
    logic [1:0]  nbytes;
    logic [23:0] wdata;
    logic [23:0] exp_miso;
    logic [31:0] exp_reg;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Strobe events {is_write, addr, data}
  logic [10:0] act_q[$];
  logic [10:0] exp_q[$];
  int   width_err = 0;
  logic wr_prev = 1'b0;
  logic rd_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_strobe) act_q.push_back({1'b1, bus.acc_addr, bus.acc_data});
    if (bus.rd_strobe) act_q.push_back({1'b0, bus.acc_addr, bus.acc_data});
    if ((bus.wr_strobe && wr_prev) || (bus.rd_strobe && rd_prev)) width_err++;
    wr_prev = bus.wr_strobe;
    rd_prev = bus.rd_strobe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_bits(input logic cpol, input logic cpha, input logic [7:0] tx,
                          input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        bus.MOSI = tx[i];
        wait_h();
        bus.SCLK = ~cpol;
        rx[i] = bus.MISO;
        wait_h();
        bus.SCLK = cpol;
      end else begin
        bus.SCLK = ~cpol;
        bus.MOSI = tx[i];
        wait_h();
        bus.SCLK = cpol;
        rx[i] = bus.MISO;
        wait_h();
      end
    end
  endtask

  task automatic select_slave(input logic cpol, input logic cpha, input string tag);
    bus.cpol = cpol;
    bus.cpha = cpha;
    bus.SCLK = cpol;
    repeat (6) @(negedge clk);
    bus.SS = 1'b0;
    wait_h();
    check({tag, " busy_selected"}, 32'(bus.busy), 32'd1);
    check({tag, " oe_selected"}, 32'(bus.miso_oe), 32'd1);
  endtask

  task automatic deselect_slave(input string tag);
    wait_h();
    bus.SS = 1'b1;
    repeat (8) @(negedge clk);
    check({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, " oe_idle"}, 32'(bus.miso_oe), 32'd0);
  endtask

  task automatic compare_events(input string tag);
    logic [10:0] a, e;
    check({tag, " event_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " event"}, 32'(a), 32'(e));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0] rx;
    logic [7:0] b;
    logic [1:0] a;
    select_slave(v.cpol, v.cpha, tag);
    spi_bits(v.cpol, v.cpha, v.cmd, 8, rx);
    check({tag, " cmd_miso"}, 32'(rx), 32'd0);
    a = v.cmd[1:0];
    for (int i = 0; i < int'(v.nbytes); i++) begin
      if (v.cmd[7]) begin
        b = v.wdata[23 - 8*i -: 8];
        spi_bits(v.cpol, v.cpha, b, 8, rx);
        exp_q.push_back({1'b1, a, b});
      end else begin
        b = v.exp_miso[23 - 8*i -: 8];
        spi_bits(v.cpol, v.cpha, 8'hFF, 8, rx);
        check($sformatf("%s miso_byte%0d", tag, i), 32'(rx), 32'(b));
        exp_q.push_back({1'b0, a, b});
      end
      a = a + 2'd1;
    end
    deselect_slave(tag);
    compare_events(tag);
    check({tag, " reg_out"}, bus.reg_out, v.exp_reg);
  endtask

  function automatic vec_t mk(input logic cpol, input logic cpha, input logic [7:0] cmd,
                              input logic [1:0] n, input logic [23:0] wd,
                              input logic [23:0] md, input logic [31:0] rg);
    vec_t v;
    v.cpol = cpol; v.cpha = cpha; v.cmd = cmd; v.nbytes = n;
    v.wdata = wd; v.exp_miso = md; v.exp_reg = rg;
    return v;
  endfunction

  vec_t vecs [8];
  logic [7:0] rx_dummy;

  initial begin
    vecs[0] = mk(1'b0, 1'b0, 8'h81, 2'd2, 24'hA53C00, 24'h000000, 32'h003CA500);
    vecs[1] = mk(1'b0, 1'b0, 8'h83, 2'd2, 24'h112200, 24'h000000, 32'h113CA522);
    vecs[2] = mk(1'b0, 1'b0, 8'h02, 2'd3, 24'h000000, 24'h3C1122, 32'h113CA522);
    vecs[3] = mk(1'b1, 1'b1, 8'h80, 2'd1, 24'h5A0000, 24'h000000, 32'h113CA55A);
    vecs[4] = mk(1'b1, 1'b1, 8'h00, 2'd1, 24'h000000, 24'h5A0000, 32'h113CA55A);
    vecs[5] = mk(1'b0, 1'b1, 8'h01, 2'd2, 24'h000000, 24'hA53C00, 32'h113CA55A);
    vecs[6] = mk(1'b1, 1'b0, 8'h82, 2'd1, 24'hC30000, 24'h000000, 32'h11C3A55A);
    vecs[7] = mk(1'b1, 1'b0, 8'h03, 2'd2, 24'h000000, 24'h115A00, 32'h11C3A55A);

    reset = 1'b1;
    bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
    repeat (3) @(negedge clk);
    check("rst MISO", 32'(bus.MISO), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst reg_out", bus.reg_out, 32'd0);
    check("rst state", 32'(bus.dbg_state), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 8; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // Abort after 4 data bits: nothing committed, regs[1] keeps 0xA5
    select_slave(1'b0, 1'b0, "abort");
    spi_bits(1'b0, 1'b0, 8'h81, 8, rx_dummy);
    spi_bits(1'b0, 1'b0, 8'h12, 4, rx_dummy);
    bus.SS = 1'b1;
    repeat (8) @(negedge clk);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort MISO", 32'(bus.MISO), 32'd0);
    compare_events("abort");
    check("abort reg_out", bus.reg_out, 32'h11C3A55A);
    run_txn(mk(1'b0, 1'b0, 8'h81, 2'd1, 24'h770000, 24'h0, 32'h11C3775A), "post_abort");

    // Reset held 3 clk in the middle of a write burst
    select_slave(1'b0, 1'b0, "midrst");
    spi_bits(1'b0, 1'b0, 8'h80, 8, rx_dummy);
    spi_bits(1'b0, 1'b0, 8'h99, 4, rx_dummy);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst MISO", 32'(bus.MISO), 32'd0);
    check("midrst miso_oe", 32'(bus.miso_oe), 32'd0);
    check("midrst strobes", {30'd0, bus.wr_strobe, bus.rd_strobe}, 32'd0);
    check("midrst acc", {22'd0, bus.acc_addr, bus.acc_data}, 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst reg_out", bus.reg_out, 32'd0);
    check("midrst state", 32'(bus.dbg_state), 32'd0);
    bus.SS = 1'b1;
    bus.SCLK = 1'b0;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst busy_after", 32'(bus.busy), 32'd0);
    compare_events("midrst");
    run_txn(mk(1'b0, 1'b0, 8'h80, 2'd1, 24'h990000, 24'h0, 32'h00000099), "post_rst_wr");
    run_txn(mk(1'b0, 1'b0, 8'h00, 2'd1, 24'h000000, 24'h990000, 32'h00000099), "post_rst_rd");

    check("strobe_width", 32'(width_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
